// File: rtl/swap_sched.sv
// swap_sched: arbitrates NREQ requesters onto one internal a/b exchange unit, one job at a time.
// Optional macro SWAP_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module swap_sched #(
    parameter int NREQ = 2,
    parameter int DW   = 8,
    parameter int CW   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*DW-1:0] a_i,
    input  logic [NREQ*DW-1:0] b_i,
    input  logic [NREQ*CW-1:0] cnt_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [2:0]         id_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [DW-1:0]      a_o,
    output logic [DW-1:0]      b_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SWAP, DONE} state_t;
    state_t state, state_nxt;

    logic [DW-1:0] a_arr   [NREQ];
    logic [DW-1:0] b_arr   [NREQ];
    logic [CW-1:0] cnt_arr [NREQ];
    logic [DW-1:0] a_q, b_q;
    logic [CW-1:0] rem_q;
    logic          found;
    logic [IW-1:0] win;

    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            a_arr[r]   = a_i[r*DW +: DW];
            b_arr[r]   = b_i[r*DW +: DW];
            cnt_arr[r] = cnt_i[r*CW +: CW];
        end
    end

`ifdef SWAP_SCHED_FIXED_PRIO_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[IW'(i)]) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] rr_last;
    int            idx;

    // Search begins just after the last winner so a held request cannot starve others.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_last) + 1 + i) % NREQ;
            if (!found && req_i[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_last <= IW'(NREQ - 1);
        else if (state == IDLE && found)
            rr_last <= win;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = LOAD;
            LOAD:    state_nxt = (rem_q == '0) ? DONE : SWAP;
            SWAP:    if (rem_q == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results are copied out on the edge entering DONE so a_o/b_o stay stable while swapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_o <= '0;
            id_o  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rem_q <= '0;
            a_o   <= '0;
            b_o   <= '0;
        end else begin
            gnt_o <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        a_q        <= a_arr[win];
                        b_q        <= b_arr[win];
                        rem_q      <= cnt_arr[win];
                        gnt_o[win] <= 1'b1;
                        id_o       <= 3'(win);
                    end
                end
                LOAD: begin
                    if (rem_q == '0) begin
                        a_o <= a_q;
                        b_o <= b_q;
                    end
                end
                SWAP: begin
                    a_q   <= b_q;
                    b_q   <= a_q;
                    rem_q <= rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        a_o <= b_q;
                        b_o <= a_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

endmodule

// File: tb/tb_swap_sched.sv
// Directed bench for swap_sched: grant order, swap counts, latency, reset abort, busy isolation.
module tb_swap_sched;
    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int CW   = 4;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] a_in;
    logic [NREQ*DW-1:0] b_in;
    logic [NREQ*CW-1:0] cnt_in;
    logic [NREQ-1:0]    gnt;
    logic [2:0]         id;
    logic               busy;
    logic               done;
    logic [DW-1:0]      a_out;
    logic [DW-1:0]      b_out;

    int checks = 0;
    int errors = 0;

    swap_sched #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req),
        .a_i    (a_in),
        .b_i    (b_in),
        .cnt_i  (cnt_in),
        .gnt_o  (gnt),
        .id_o   (id),
        .busy_o (busy),
        .done_o (done),
        .a_o    (a_out),
        .b_o    (b_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_job(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [CW-1:0] c);
        a_in[r*DW +: DW]   = a;
        b_in[r*DW +: DW]   = b;
        cnt_in[r*CW +: CW] = c;
    endtask

    // Drives a request, then records grant latency, grant vector, done latency and results.
    task automatic serve(input logic [NREQ-1:0] req_v, input bit hold,
                         output int gnt_lat, output logic [NREQ-1:0] gnt_seen,
                         output int done_lat, output int gnt_extra,
                         output logic [DW-1:0] ra, output logic [DW-1:0] rb,
                         output logic [2:0] rid);
        gnt_lat = 0; done_lat = 0; gnt_extra = 0;
        gnt_seen = '0; ra = '0; rb = '0; rid = '0;
        req = req_v;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (gnt !== '0) begin
                gnt_lat = k;
                break;
            end
        end
        gnt_seen = gnt;
        if (!hold) req = '0;
        if (gnt_lat != 0) begin
            for (int d = 1; d <= 40; d++) begin
                @(negedge clk);
                if (gnt !== '0) gnt_extra++;
                if (done === 1'b1) begin
                    done_lat = d;
                    ra = a_out;
                    rb = b_out;
                    rid = id;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b11;
        repeat (3) @(negedge clk);
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %0h want 0", gnt); end
        checks++; if (id !== 3'd0) begin errors++; $display("FAIL reset_id: got %0h want 0", id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (a_out !== 8'h00) begin errors++; $display("FAIL reset_a: got %0h want 0", a_out); end
        checks++; if (b_out !== 8'h00) begin errors++; $display("FAIL reset_b: got %0h want 0", b_out); end
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_basic();
        int gl, dl, ge;
        logic [NREQ-1:0] gs;
        logic [DW-1:0] ra, rb;
        logic [2:0] rid;
        set_job(0, 8'h11, 8'h22, 4'd3);
        serve(2'b01, 1'b0, gl, gs, dl, ge, ra, rb, rid);
        checks++; if (gl !== 1) begin errors++; $display("FAIL basic_gnt_lat: got %0d want 1", gl); end
        checks++; if (gs !== 2'b01) begin errors++; $display("FAIL basic_gnt: got %0h want 1", gs); end
        checks++; if (ge !== 0) begin errors++; $display("FAIL basic_gnt_width: extra %0d want 0", ge); end
        checks++; if (dl !== 4) begin errors++; $display("FAIL basic_done_lat: got %0d want 4", dl); end
        checks++; if (ra !== 8'h22) begin errors++; $display("FAIL basic_a: got %0h want 22", ra); end
        checks++; if (rb !== 8'h11) begin errors++; $display("FAIL basic_b: got %0h want 11", rb); end
        checks++; if (rid !== 3'd0) begin errors++; $display("FAIL basic_id: got %0d want 0", rid); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %0b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy %0b want 0", busy); end
        checks++; if (a_out !== 8'h22) begin errors++; $display("FAIL basic_a_hold: got %0h want 22", a_out); end
    endtask

    task automatic test_zero_count();
        int gl, dl, ge;
        logic [NREQ-1:0] gs;
        logic [DW-1:0] ra, rb;
        logic [2:0] rid;
        set_job(1, 8'hA5, 8'h5A, 4'd0);
        serve(2'b10, 1'b0, gl, gs, dl, ge, ra, rb, rid);
        checks++; if (gs !== 2'b10) begin errors++; $display("FAIL zero_gnt: got %0h want 2", gs); end
        checks++; if (dl !== 1) begin errors++; $display("FAIL zero_done_lat: got %0d want 1", dl); end
        checks++; if (ra !== 8'hA5) begin errors++; $display("FAIL zero_a: got %0h want a5", ra); end
        checks++; if (rb !== 8'h5A) begin errors++; $display("FAIL zero_b: got %0h want 5a", rb); end
        checks++; if (rid !== 3'd1) begin errors++; $display("FAIL zero_id: got %0d want 1", rid); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int gl, dl, ge;
        logic [NREQ-1:0] gs, exp_g;
        logic [DW-1:0] ra, rb, exp_a, exp_b;
        logic [2:0] rid;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_job(0, 8'h10, 8'h20, 4'd1);
        set_job(1, 8'h30, 8'h40, 4'd1);
        for (int i = 0; i < 4; i++) begin
            serve(2'b11, 1'b1, gl, gs, dl, ge, ra, rb, rid);
`ifdef SWAP_SCHED_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            exp_a = (exp_g == 2'b01) ? 8'h20 : 8'h40;
            exp_b = (exp_g == 2'b01) ? 8'h10 : 8'h30;
            checks++; if (gs !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %0h want %0h", i, gs, exp_g); end
            checks++; if (gl !== ((i == 0) ? 1 : 2)) begin errors++; $display("FAIL rr_gnt_lat[%0d]: got %0d want %0d", i, gl, (i == 0) ? 1 : 2); end
            checks++; if (dl !== 2) begin errors++; $display("FAIL rr_done_lat[%0d]: got %0d want 2", i, dl); end
            checks++; if (ra !== exp_a) begin errors++; $display("FAIL rr_a[%0d]: got %0h want %0h", i, ra, exp_a); end
            checks++; if (rb !== exp_b) begin errors++; $display("FAIL rr_b[%0d]: got %0h want %0h", i, rb, exp_b); end
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_max_count();
        int gl, dl, ge;
        logic [NREQ-1:0] gs;
        logic [DW-1:0] ra, rb;
        logic [2:0] rid;
        set_job(0, 8'h01, 8'h02, 4'd15);
        serve(2'b01, 1'b0, gl, gs, dl, ge, ra, rb, rid);
        checks++; if (gl !== 1) begin errors++; $display("FAIL max_gnt_lat: got %0d want 1", gl); end
        checks++; if (dl !== 16) begin errors++; $display("FAIL max_done_lat: got %0d want 16", dl); end
        checks++; if (ra !== 8'h02) begin errors++; $display("FAIL max_a: got %0h want 2", ra); end
        checks++; if (rb !== 8'h01) begin errors++; $display("FAIL max_b: got %0h want 1", rb); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        int gl, dl, ge, k, seen_done;
        logic [NREQ-1:0] gs;
        logic [DW-1:0] ra, rb;
        logic [2:0] rid;
        set_job(1, 8'h33, 8'h44, 4'd6);
        req = 2'b10;
        k = 0;
        while (k < 40 && gnt === '0) begin
            @(negedge clk);
            k++;
        end
        req = '0;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL abort_gnt: got %0h want 2", gnt); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid: got %0b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL abort_gnt0: got %0h want 0", gnt); end
        checks++; if (id !== 3'd0) begin errors++; $display("FAIL abort_id: got %0d want 0", id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", busy); end
        checks++; if (a_out !== 8'h00) begin errors++; $display("FAIL abort_a: got %0h want 0", a_out); end
        checks++; if (b_out !== 8'h00) begin errors++; $display("FAIL abort_b: got %0h want 0", b_out); end
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done: activity %0d want 0", seen_done); end
        set_job(1, 8'h55, 8'h66, 4'd2);
        serve(2'b10, 1'b0, gl, gs, dl, ge, ra, rb, rid);
        checks++; if (gs !== 2'b10) begin errors++; $display("FAIL after_abort_gnt: got %0h want 2", gs); end
        checks++; if (dl !== 3) begin errors++; $display("FAIL after_abort_done_lat: got %0d want 3", dl); end
        checks++; if (ra !== 8'h55 || rb !== 8'h66) begin errors++; $display("FAIL after_abort_ab: got %0h/%0h want 55/66", ra, rb); end
        checks++; if (rid !== 3'd1) begin errors++; $display("FAIL after_abort_id: got %0d want 1", rid); end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int gl, dl, ge, k, d;
        logic [NREQ-1:0] gs;
        logic [DW-1:0] ra, rb, da, db;
        logic [2:0] rid, did;
        set_job(0, 8'h77, 8'h88, 4'd2);
        set_job(1, 8'h99, 8'hAA, 4'd0);
        req = 2'b01;
        k = 0;
        while (k < 40 && gnt === '0) begin
            @(negedge clk);
            k++;
        end
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL busy_gnt: got %0h want 1", gnt); end
        set_job(0, 8'hEE, 8'hFF, 4'd9);
        req = 2'b10;
        d = 0;
        da = '0; db = '0; did = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (gnt !== '0 && done !== 1'b1) begin
                errors++; checks++;
                $display("FAIL busy_stray_gnt: got %0h want 0", gnt);
            end
            if (done === 1'b1) begin
                d = i; da = a_out; db = b_out; did = id;
                break;
            end
        end
        checks++; if (d !== 3) begin errors++; $display("FAIL busy_done_lat: got %0d want 3", d); end
        checks++; if (da !== 8'h77 || db !== 8'h88) begin errors++; $display("FAIL busy_ab: got %0h/%0h want 77/88", da, db); end
        checks++; if (did !== 3'd0) begin errors++; $display("FAIL busy_id: got %0d want 0", did); end
        serve(2'b10, 1'b0, gl, gs, dl, ge, ra, rb, rid);
        checks++; if (gl !== 2) begin errors++; $display("FAIL pend_gnt_lat: got %0d want 2", gl); end
        checks++; if (gs !== 2'b10) begin errors++; $display("FAIL pend_gnt: got %0h want 2", gs); end
        checks++; if (ra !== 8'h99 || rb !== 8'hAA) begin errors++; $display("FAIL pend_ab: got %0h/%0h want 99/aa", ra, rb); end
        @(negedge clk);
    endtask

    task automatic test_drop_before_grant();
        int k, d, stray;
        set_job(0, 8'h12, 8'h34, 4'd3);
        set_job(1, 8'h56, 8'h78, 4'd1);
        req = 2'b01;
        k = 0;
        while (k < 40 && gnt === '0) begin
            @(negedge clk);
            k++;
        end
        req = '0;
        @(negedge clk);
        req = 2'b10;
        @(negedge clk);
        req = '0;
        d = 0;
        while (d < 40 && done !== 1'b1) begin
            @(negedge clk);
            d++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL drop_done: got %0b want 1", done); end
        checks++; if (a_out !== 8'h34 || b_out !== 8'h12) begin errors++; $display("FAIL drop_ab: got %0h/%0h want 34/12", a_out, b_out); end
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (gnt !== '0 || busy !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL drop_not_served: activity %0d want 0", stray); end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        a_in = '0;
        b_in = '0;
        cnt_in = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_count();
        test_round_robin();
        test_max_count();
        test_reset_mid_job();
        test_busy_ignore();
        test_drop_before_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
